// File: rtl/alarm_set_ctrl_if.sv
// Signal bundle between alarm_set_ctrl and its neighbours (buttons, time counter, alarm store).
// snooze_btn exists only when SNOOZE_EN is defined. state_dbg mirrors the controller FSM state.
interface alarm_set_ctrl_if;
  logic       set_btn;
  logic       inc_btn;
  logic       stop_btn;
  logic       alarm_en;
  logic       sec_tick;
  logic [7:0] cur_sec;
  logic [7:0] cur_min;
  logic [7:0] cur_hour;
  logic [7:0] alm_sec;
  logic [7:0] alm_min;
  logic [7:0] alm_hour;
  logic [7:0] wr_sec;
  logic [7:0] wr_min;
  logic [7:0] wr_hour;
  logic       wr_en;
  logic [1:0] edit_field;
  logic       ringing;
  logic [2:0] state_dbg;
`ifdef SNOOZE_EN
  logic       snooze_btn;

  modport master (
    output set_btn, inc_btn, stop_btn, alarm_en, sec_tick, snooze_btn,
    output cur_sec, cur_min, cur_hour, alm_sec, alm_min, alm_hour,
    input  wr_sec, wr_min, wr_hour, wr_en, edit_field, ringing, state_dbg
  );

  modport slave (
    input  set_btn, inc_btn, stop_btn, alarm_en, sec_tick, snooze_btn,
    input  cur_sec, cur_min, cur_hour, alm_sec, alm_min, alm_hour,
    output wr_sec, wr_min, wr_hour, wr_en, edit_field, ringing, state_dbg
  );
`else
  modport master (
    output set_btn, inc_btn, stop_btn, alarm_en, sec_tick,
    output cur_sec, cur_min, cur_hour, alm_sec, alm_min, alm_hour,
    input  wr_sec, wr_min, wr_hour, wr_en, edit_field, ringing, state_dbg
  );

  modport slave (
    input  set_btn, inc_btn, stop_btn, alarm_en, sec_tick,
    input  cur_sec, cur_min, cur_hour, alm_sec, alm_min, alm_hour,
    output wr_sec, wr_min, wr_hour, wr_en, edit_field, ringing, state_dbg
  );
`endif
endinterface

// File: rtl/alarm_set_ctrl.sv
// Alarm-time edit sequencer and ring controller. Optional snooze support is compiled in
// with the SNOOZE_EN macro. All buttons are one-cycle pulses; every output is a flop.
module alarm_set_ctrl #(
  parameter logic [7:0] RING_SECS  = 8'd30,
  parameter int         SNOOZE_MIN = 5
) (
  input  logic           clk,
  input  logic           reset,
  alarm_set_ctrl_if.slave bus
);

  if (RING_SECS == 8'd0 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_param
    $error("alarm_set_ctrl: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT_H,
    S_EDIT_M,
    S_EDIT_S,
    S_COMMIT,
    S_RING
`ifdef SNOOZE_EN
    , S_SNOOZE
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wr_hour_q, wr_hour_d;
  logic [7:0] wr_min_q, wr_min_d;
  logic [7:0] wr_sec_q, wr_sec_d;
  logic       wr_en_q, wr_en_d;
  logic [1:0] edit_field_q, edit_field_d;
  logic       ringing_q, ringing_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic       alm_match;
`ifdef SNOOZE_EN
  logic [7:0]  snz_hour_q, snz_hour_d;
  logic [7:0]  snz_min_q, snz_min_d;
  logic [7:0]  snz_sec_q, snz_sec_d;
  logic        snz_match;
  logic [15:0] snz_target;
`endif

  // Any illegal BCD value or the field maximum rolls to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v >= max_v) return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
    else return v + 8'd1;
  endfunction

`ifdef SNOOZE_EN
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Returns {hour, min} of the alarm pushed forward by SNOOZE_MIN minutes.
  function automatic logic [15:0] snooze_add(input logic [7:0] h, input logic [7:0] m);
    int hb;
    int mb;
    hb = int'(h[7:4]) * 10 + int'(h[3:0]);
    mb = int'(m[7:4]) * 10 + int'(m[3:0]) + SNOOZE_MIN;
    if (mb >= 60) begin
      mb = mb - 60;
      hb = hb + 1;
    end
    if (hb >= 24) hb = hb - 24;
    return {to_bcd(hb), to_bcd(mb)};
  endfunction

  assign snz_target = snooze_add(bus.alm_hour, bus.alm_min);
  assign snz_match  = bus.sec_tick && bus.cur_hour == snz_hour_q &&
                      bus.cur_min == snz_min_q && bus.cur_sec == snz_sec_q;
`endif

  assign alm_match = bus.alarm_en && bus.sec_tick && bus.cur_hour == bus.alm_hour &&
                     bus.cur_min == bus.alm_min && bus.cur_sec == bus.alm_sec;

  always_comb begin
    state_d    = state_q;
    wr_hour_d  = wr_hour_q;
    wr_min_d   = wr_min_q;
    wr_sec_d   = wr_sec_q;
    ring_cnt_d = ring_cnt_q;
`ifdef SNOOZE_EN
    snz_hour_d = snz_hour_q;
    snz_min_d  = snz_min_q;
    snz_sec_d  = snz_sec_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.set_btn) begin
          wr_hour_d = bus.alm_hour;
          wr_min_d  = bus.alm_min;
          wr_sec_d  = bus.alm_sec;
          state_d   = S_EDIT_H;
        end else if (alm_match) begin
          ring_cnt_d = 8'd0;
          state_d    = S_RING;
        end
      end
      S_EDIT_H: begin
        if (bus.set_btn)      state_d   = S_EDIT_M;
        else if (bus.inc_btn) wr_hour_d = bcd_inc(wr_hour_q, 8'h23);
      end
      S_EDIT_M: begin
        if (bus.set_btn)      state_d  = S_EDIT_S;
        else if (bus.inc_btn) wr_min_d = bcd_inc(wr_min_q, 8'h59);
      end
      S_EDIT_S: begin
        if (bus.set_btn)      state_d  = S_COMMIT;
        else if (bus.inc_btn) wr_sec_d = bcd_inc(wr_sec_q, 8'h59);
      end
      S_COMMIT: state_d = S_IDLE;
      S_RING: begin
        if (bus.stop_btn || !bus.alarm_en) begin
          state_d = S_IDLE;
        end
`ifdef SNOOZE_EN
        else if (bus.snooze_btn) begin
          snz_hour_d = snz_target[15:8];
          snz_min_d  = snz_target[7:0];
          snz_sec_d  = bus.alm_sec;
          state_d    = S_SNOOZE;
        end
`endif
        else if (bus.sec_tick) begin
          ring_cnt_d = ring_cnt_q + 8'd1;
          if (ring_cnt_d == RING_SECS) state_d = S_IDLE;
        end
      end
`ifdef SNOOZE_EN
      S_SNOOZE: begin
        if (bus.stop_btn || !bus.alarm_en || bus.set_btn) begin
          state_d = S_IDLE;
        end else if (snz_match) begin
          ring_cnt_d = 8'd0;
          state_d    = S_RING;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they change with it.
    wr_en_d   = (state_d == S_COMMIT);
    ringing_d = (state_d == S_RING);
    case (state_d)
      S_EDIT_H: edit_field_d = 2'd1;
      S_EDIT_M: edit_field_d = 2'd2;
      S_EDIT_S: edit_field_d = 2'd3;
      default:  edit_field_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_hour_q    <= 8'h00;
      wr_min_q     <= 8'h00;
      wr_sec_q     <= 8'h00;
      wr_en_q      <= 1'b0;
      edit_field_q <= 2'd0;
      ringing_q    <= 1'b0;
      ring_cnt_q   <= 8'd0;
`ifdef SNOOZE_EN
      snz_hour_q   <= 8'h00;
      snz_min_q    <= 8'h00;
      snz_sec_q    <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      wr_hour_q    <= wr_hour_d;
      wr_min_q     <= wr_min_d;
      wr_sec_q     <= wr_sec_d;
      wr_en_q      <= wr_en_d;
      edit_field_q <= edit_field_d;
      ringing_q    <= ringing_d;
      ring_cnt_q   <= ring_cnt_d;
`ifdef SNOOZE_EN
      snz_hour_q   <= snz_hour_d;
      snz_min_q    <= snz_min_d;
      snz_sec_q    <= snz_sec_d;
`endif
    end
  end

  assign bus.wr_hour    = wr_hour_q;
  assign bus.wr_min     = wr_min_q;
  assign bus.wr_sec     = wr_sec_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.edit_field = edit_field_q;
  assign bus.ringing    = ringing_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Bench for alarm_set_ctrl: directed edit/ring scenarios plus randomized edit sessions and
// ring sequences checked against a seconds-of-day reference model. Snooze steps need SNOOZE_EN.
module tb_alarm_set_ctrl;
  localparam logic [7:0] RS = 8'd3;
  localparam int         SM = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alarm_set_ctrl_if bus ();

  alarm_set_ctrl #(.RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests   = 0;
  int n_fail    = 0;
  int wr_pulses = 0;

  always @(negedge clk) if (bus.wr_en === 1'b1) wr_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: pulses set up before the call are held for exactly one edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.set_btn  = 1'b0;
    bus.inc_btn  = 1'b0;
    bus.stop_btn = 1'b0;
    bus.sec_tick = 1'b0;
`ifdef SNOOZE_EN
    bus.snooze_btn = 1'b0;
`endif
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  // Reference increment: decode to an integer, add one modulo the field range.
  function automatic logic [7:0] m_inc_n(input logic [7:0] v, input int n, input int modulus);
    int t;
    int u;
    int val;
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) begin
      t = int'(r[7:4]);
      u = int'(r[3:0]);
      if (t > 9 || u > 9 || t * 10 + u >= modulus) val = 0;
      else val = (t * 10 + u + 1) % modulus;
      r = bcd(val);
    end
    return r;
  endfunction

  task automatic set_cur(input int s);
    bus.cur_hour = bcd(s / 3600);
    bus.cur_min  = bcd((s / 60) % 60);
    bus.cur_sec  = bcd(s % 60);
  endtask

  task automatic set_alm(input int s);
    bus.alm_hour = bcd(s / 3600);
    bus.alm_min  = bcd((s / 60) % 60);
    bus.alm_sec  = bcd(s % 60);
  endtask

  task automatic run_edit(input logic [7:0] ah, input logic [7:0] am, input logic [7:0] as_,
                          input int nh, input int nm, input int ns,
                          input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                          input string tag);
    int p0;
    bus.alm_hour = ah; bus.alm_min = am; bus.alm_sec = as_;
    bus.cur_hour = ah; bus.cur_min = am; bus.cur_sec = as_;
    bus.alarm_en = 1'b1;
    bus.sec_tick = 1'b1;
    bus.set_btn  = 1'b1;
    cyc();
    check({tag, "_field_h"}, bus.edit_field, 2'd1);
    check({tag, "_no_ring"}, bus.ringing, 1'b0);
    check({tag, "_load_h"}, bus.wr_hour, ah);
    repeat (nh) begin bus.inc_btn = 1'b1; bus.sec_tick = 1'($urandom_range(0, 1)); cyc(); end
    bus.set_btn = 1'b1; cyc();
    check({tag, "_field_m"}, bus.edit_field, 2'd2);
    check({tag, "_hour"}, bus.wr_hour, eh);
    repeat (nm) begin bus.inc_btn = 1'b1; bus.sec_tick = 1'($urandom_range(0, 1)); cyc(); end
    bus.set_btn = 1'b1; cyc();
    check({tag, "_field_s"}, bus.edit_field, 2'd3);
    check({tag, "_min"}, bus.wr_min, em);
    repeat (ns) begin bus.inc_btn = 1'b1; bus.sec_tick = 1'($urandom_range(0, 1)); cyc(); end
    p0 = wr_pulses;
    bus.set_btn = 1'b1; cyc();
    check({tag, "_wr_en"}, bus.wr_en, 1'b1);
    check({tag, "_field_0"}, bus.edit_field, 2'd0);
    check({tag, "_c_hour"}, bus.wr_hour, eh);
    check({tag, "_c_min"}, bus.wr_min, em);
    check({tag, "_c_sec"}, bus.wr_sec, es);
    cyc();
    check({tag, "_wr_en_drop"}, bus.wr_en, 1'b0);
    check({tag, "_hold_sec"}, bus.wr_sec, es);
    check({tag, "_one_pulse"}, wr_pulses - p0, 1);
    check({tag, "_ring_end"}, bus.ringing, 1'b0);
    bus.alarm_en = 1'b0;
  endtask

  initial begin
    logic [7:0] ah, am, as_;
    int nh, nm, ns, p0;
    int cur_s, alm_s;
    bit m_ring;
    int m_cnt;
    bit tick, stop, en;

    reset = 1'b1;
    bus.set_btn = 1'b0; bus.inc_btn = 1'b0; bus.stop_btn = 1'b0;
    bus.alarm_en = 1'b0; bus.sec_tick = 1'b0;
`ifdef SNOOZE_EN
    bus.snooze_btn = 1'b0;
`endif
    set_cur(0);
    bus.alm_hour = 8'h12; bus.alm_min = 8'h30; bus.alm_sec = 8'h00;
    cyc(); cyc();
    check("rst_wr_hour", bus.wr_hour, 8'h00);
    check("rst_wr_min", bus.wr_min, 8'h00);
    check("rst_wr_sec", bus.wr_sec, 8'h00);
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_field", bus.edit_field, 2'd0);
    check("rst_ringing", bus.ringing, 1'b0);
    reset = 1'b0;
    cyc();

    // Basic edit: 12:30:00 -> 14:31:00
    run_edit(8'h12, 8'h30, 8'h00, 2, 1, 0, 8'h14, 8'h31, 8'h00, "edit1");
    // Wrap and illegal-value cases
    run_edit(8'h23, 8'h59, 8'h09, 1, 1, 1, 8'h00, 8'h00, 8'h10, "wrap");
    run_edit(8'h3A, 8'h09, 8'h59, 1, 1, 1, 8'h00, 8'h10, 8'h00, "illegal");
    run_edit(8'h19, 8'hA5, 8'h60, 1, 2, 1, 8'h20, 8'h01, 8'h00, "illegal2");

    // Randomized edit sessions
    for (int i = 0; i < 8; i++) begin
      ah  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : bcd($urandom_range(0, 23));
      am  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : bcd($urandom_range(0, 59));
      as_ = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : bcd($urandom_range(0, 59));
      nh = $urandom_range(0, 30); nm = $urandom_range(0, 65); ns = $urandom_range(0, 65);
      run_edit(ah, am, as_, nh, nm, ns,
               m_inc_n(ah, nh, 24), m_inc_n(am, nm, 60), m_inc_n(as_, ns, 60), "rnd_edit");
    end

    // Ring and timeout after RS ticks, no retrigger
    set_alm(6 * 3600); set_cur(6 * 3600);
    bus.alarm_en = 1'b1; bus.sec_tick = 1'b1; cyc();
    check("ring_start", bus.ringing, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("ring_hold", bus.ringing, 1'b1);
      set_cur(6 * 3600 + i); bus.sec_tick = 1'b1; cyc();
      check("ring_count", bus.ringing, (i < 3) ? 1'b1 : 1'b0);
    end
    for (int i = 4; i <= 6; i++) begin
      set_cur(6 * 3600 + i); bus.sec_tick = 1'b1; cyc();
      check("no_retrigger", bus.ringing, 1'b0);
    end
    check("timeout_field", bus.edit_field, 2'd0);

    // Stop button and alarm_en drop while ringing
    set_cur(6 * 3600); bus.sec_tick = 1'b1; cyc();
    check("ring2_start", bus.ringing, 1'b1);
    bus.stop_btn = 1'b1; bus.set_btn = 1'b1; bus.inc_btn = 1'b1; cyc();
    check("stop_ring", bus.ringing, 1'b0);
    check("stop_no_edit", bus.edit_field, 2'd0);
    bus.sec_tick = 1'b1; cyc();
    check("ring3_start", bus.ringing, 1'b1);
    bus.set_btn = 1'b1; cyc();
    check("ring_ignores_set", bus.edit_field, 2'd0);
    bus.alarm_en = 1'b0; cyc();
    check("en_drop_ring", bus.ringing, 1'b0);
    bus.sec_tick = 1'b1; cyc();
    check("disabled_match", bus.ringing, 1'b0);
    cyc();
    check("disabled_match2", bus.ringing, 1'b0);

    // set+inc in EDIT_M, then reset in EDIT_S
    bus.alm_hour = 8'h12; bus.alm_min = 8'h30; bus.alm_sec = 8'h00;
    p0 = wr_pulses;
    bus.set_btn = 1'b1; cyc();
    bus.set_btn = 1'b1; cyc();
    check("simul_field_m", bus.edit_field, 2'd2);
    bus.set_btn = 1'b1; bus.inc_btn = 1'b1; cyc();
    check("simul_field_s", bus.edit_field, 2'd3);
    check("simul_min_same", bus.wr_min, 8'h30);
    reset = 1'b1; bus.set_btn = 1'b1; cyc();
    reset = 1'b0;
    check("rst_edit_field", bus.edit_field, 2'd0);
    check("rst_edit_hour", bus.wr_hour, 8'h00);
    check("rst_edit_min", bus.wr_min, 8'h00);
    check("rst_edit_wr_en", bus.wr_en, 1'b0);
    cyc(); cyc();
    check("rst_edit_no_commit", wr_pulses - p0, 0);
    check("rst_edit_idle", bus.edit_field, 2'd0);

    // Randomized ring sequences against a seconds-of-day model
    for (int sc = 0; sc < 6; sc++) begin
      reset = 1'b1; cyc(); reset = 1'b0;
      cur_s = (sc == 0) ? 86397 : $urandom_range(0, 86399);
      alm_s = (cur_s + $urandom_range(1, 6)) % 86400;
      set_alm(alm_s);
      m_ring = 1'b0; m_cnt = 0;
      for (int c = 0; c < 70; c++) begin
        tick = ($urandom_range(0, 2) == 0);
        stop = ($urandom_range(0, 29) == 0);
        en   = ($urandom_range(0, 39) != 0);
        set_cur(cur_s);
        bus.sec_tick = tick; bus.stop_btn = stop; bus.alarm_en = en;
        if (m_ring) begin
          if (stop || !en) m_ring = 1'b0;
          else if (tick) begin
            m_cnt++;
            if (m_cnt == int'(RS)) m_ring = 1'b0;
          end
        end else if (en && tick && cur_s == alm_s) begin
          m_ring = 1'b1;
          m_cnt = 0;
        end
        cyc();
        check("rnd_ring", bus.ringing, m_ring);
        if (tick) cur_s = (cur_s + 1) % 86400;
      end
    end
    bus.alarm_en = 1'b0;

`ifdef SNOOZE_EN
    // Snooze from 23:58:10 wraps to 00:03:10
    reset = 1'b1; cyc(); reset = 1'b0;
    set_alm(23 * 3600 + 58 * 60 + 10); set_cur(23 * 3600 + 58 * 60 + 10);
    bus.alarm_en = 1'b1; bus.sec_tick = 1'b1; cyc();
    check("snz_ring", bus.ringing, 1'b1);
    bus.snooze_btn = 1'b1; cyc();
    check("snz_quiet", bus.ringing, 1'b0);
    set_cur(23 * 3600 + 58 * 60 + 11); bus.sec_tick = 1'b1; cyc();
    check("snz_wait", bus.ringing, 1'b0);
    set_cur(3 * 60 + 10); bus.sec_tick = 1'b1; cyc();
    check("snz_rering", bus.ringing, 1'b1);
    check("snz_alm_kept", bus.alm_min, 8'h58);
    bus.snooze_btn = 1'b1; cyc();
    check("snz2_quiet", bus.ringing, 1'b0);
    bus.set_btn = 1'b1; cyc();
    check("snz_set_consumed", bus.edit_field, 2'd0);
    set_cur(8 * 60 + 10); bus.sec_tick = 1'b1; cyc();
    check("snz_cancelled", bus.ringing, 1'b0);
    bus.alarm_en = 1'b0;
`endif

    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_set_ctrl.md
Name: alarm_set_ctrl

Overview:
Controller that sequences the alarm-time storage register. It runs the user edit sequence (hour -> min -> sec) from debounced buttons and presents BCD edit data with a one-cycle commit strobe to the store. It compares current time against the stored alarm and drives the ringing output. Sits between the button debouncers, the time counter, and the alarm-store register.

Parameters:
RING_SECS, 8'd30, ring duration in sec_tick pulses (legal 1..255)
SNOOZE_MIN, 5, snooze offset in minutes (legal 1..59); used only when SNOOZE_EN is defined

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
set_btn  in  1  one-cycle pulse; enter edit / advance field
inc_btn  in  1  one-cycle pulse; increment selected field
stop_btn  in  1  one-cycle pulse; silence alarm
alarm_en  in  1  level; alarm armed
sec_tick  in  1  one-cycle pulse, 1 Hz, aligned with time-counter update
cur_sec, cur_min, cur_hour  in  8 each  current time, packed BCD
alm_sec, alm_min, alm_hour  in  8 each  stored alarm read-back, packed BCD
wr_sec, wr_min, wr_hour  out  8 each  edit buffer to alarm-store data inputs
wr_en  out  1  one-cycle commit strobe qualifying wr_*
edit_field  out  2  0 none, 1 hour, 2 min, 3 sec
ringing  out  1  alarm sounding

Behaviour:
- One clock, clk. Reset is synchronous and active-high: on a rising clk edge with reset=1, state=IDLE, wr_*=8'h00, wr_en=0, edit_field=0, ringing=0, ring counter=0. Reset overrides all events, including mid-edit, which discards the buffer without a commit.
- All outputs are registered. Response appears the cycle after the triggering input.
- States: IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT, RING (+SNOOZE with macro).
- IDLE:
  - set_btn: load wr_* from alm_* and go to EDIT_H.
  - Alarm match: alarm_en=1, sec_tick=1, and cur_* == alm_* on all 3 fields in that cycle. Go to RING and clear the ring counter.
  - If set_btn and a match occur in the same cycle, set_btn wins.
- EDIT_H / EDIT_M / EDIT_S: edit_field = 1/2/3.
  - inc_btn increments the selected field in BCD. Hour wraps 8'h23 -> 8'h00. Min and sec wrap 8'h59 -> 8'h00. Units carry 9 -> tens+1.
  - A field holding an illegal BCD value (nibble > 9 or out of range) increments to 8'h00.
  - set_btn advances H -> M -> S -> COMMIT.
  - If set_btn and inc_btn arrive in the same cycle, inc_btn is ignored.
  - No alarm match is evaluated while editing.
- COMMIT: wr_en=1 for exactly one cycle with wr_* stable, edit_field=0, then go to IDLE. wr_* holds its value after the commit.
- RING: ringing=1.
  - Each sec_tick increments the ring counter. When the counter reaches RING_SECS, go to IDLE.
  - stop_btn or alarm_en=0 goes to IDLE next cycle, with ringing=0 from that cycle.
  - Priority: stop_btn / alarm_en=0 > snooze_btn > timeout.
  - set_btn and inc_btn are ignored in RING.
- No retrigger: the match is evaluated only on sec_tick cycles, and time advances on every tick.

Optional Feature:
SNOOZE_EN
- Defined:
  - Adds port snooze_btn (in, 1, one-cycle pulse) and state SNOOZE.
  - snooze_btn in RING: ringing=0, go to SNOOZE, and latch target = alm_* + SNOOZE_MIN minutes. Minutes wrap 59 -> 00 with hour carry; hour wraps 23 -> 00; seconds are unchanged.
  - SNOOZE: a sec_tick match of cur_* against the target goes to RING with the counter cleared.
  - stop_btn, alarm_en=0, or set_btn in SNOOZE goes to IDLE. set_btn is consumed and does not also enter edit.
  - The stored alarm is never modified by snooze.
- Undefined: no snooze_btn port and no SNOOZE state. Behaviour is otherwise identical.

Test Plan:
1. Reset with alm_*=12:30:00, then set_btn, inc_btn x2, set_btn, inc_btn, set_btn, set_btn -> edit_field 1,2,3,0 in turn; one wr_en pulse with wr_hour=8'h14, wr_min=8'h31, wr_sec=8'h00.
2. Wrap cases: hour field 8'h23 + inc -> 8'h00; min field 8'h59 + inc -> 8'h00; min 8'h09 + inc -> 8'h10; illegal 8'h3A + inc -> 8'h00.
3. alarm_en=1, alm=06:00:00, cur=06:00:00 with sec_tick -> ringing=1 next cycle. RING_SECS=3: after 3 ticks ringing=0 and state is IDLE with no retrigger.
4. While ringing, stop_btn -> ringing=0 next cycle. Repeat with alarm_en dropped -> same result. Match with alarm_en=0 -> ringing stays 0.
5. Simultaneous events: set_btn+inc_btn in EDIT_M -> field advances and the value is unchanged. reset asserted in EDIT_S -> IDLE with wr_en never pulsing and wr_*=8'h00.
6. SNOOZE_EN, SNOOZE_MIN=5, alm=23:58:10: snooze_btn while ringing -> ringing=0; cur=00:03:10 with sec_tick -> ringing=1.
